// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: responder FSM states and sizing constants.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_dmem_state;

  localparam int DMEM_WORD_BYTES = 4;
  localparam int DMEM_WAIT_W     = 4;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request and response channels between the core (master) and the data memory (slave).
interface mips_dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mips_dmem_bytes.sv
// Byte-addressable storage: 4-lane masked write port and 4-byte combinational little-endian read port.
module mips_dmem_bytes
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    for (int k = 0; k < DMEM_WORD_BYTES; k++) begin
      if (we[k]) mem[addr + AW'(k)] <= wdata[8*k +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < DMEM_WORD_BYTES; k++) begin
      rdata[8*k +: 8] = mem[addr + AW'(k)];
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Wait-state data-memory responder for the MIPS core; define MIPS_DMEM_ALIGN_CHECK_EN to reject unaligned words.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_BASE = 32'(DEPTH_BYTES - DMEM_WORD_BYTES);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
    DMEM_WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  t_dmem_state state, state_next;
  logic [DMEM_WAIT_W-1:0] cnt;
  logic        drained;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        cap_write;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  logic        accept, enter_resp, cur_write, cur_err;
  logic [31:0] cur_addr, cur_wdata, rd_word;
  logic [3:0]  cur_be, lane_we;

  assign accept = (state == IDLE) && bus.req_valid && ready_q;

  // With zero wait states RESP is entered on the accepting edge, so the live bus is used.
  assign cur_write = (state == IDLE) ? bus.req_write : cap_write;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
  assign cur_be    = (state == IDLE) ? bus.req_be    : cap_be;

  always_comb begin
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    cur_err = (cur_addr > LAST_BASE) || (cur_addr[1:0] != 2'b00);
`else
    cur_err = (cur_addr > LAST_BASE);
`endif
  end

  assign enter_resp = (state_next == RESP) && (state != RESP);
  assign lane_we    = (enter_resp && cur_write && !cur_err) ? cur_be : 4'b0000;

  mips_dmem_bytes #(.DEPTH_BYTES(DEPTH_BYTES)) u_bytes (
    .clk   (clk),
    .we    (lane_we),
    .addr  (cur_addr[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (rd_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) state_next = WAIT;
          else                 state_next = RESP;
        end
      end
      WAIT:    if (drained) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // drained marks the cycle after the counter has read zero, which ends the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      drained <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state == IDLE) && !accept;
      drained <= (state == WAIT) && (cnt == '0) && !drained;
      if (accept)                           cnt <= WAIT_LOAD;
      else if ((state == WAIT) && (cnt != '0)) cnt <= cnt - 1'b1;
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_write) ? 32'h0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= bus.req_write;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_be    <= bus.req_be;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: one instance with 1 wait state, one with 3, sharing a clock.
module tb_mips_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n[2];
  logic        req_valid[2], req_write[2], rsp_ready[2];
  logic [31:0] req_addr[2], req_wdata[2];
  logic [3:0]  req_be[2];
  logic        req_ready[2], rsp_valid[2], rsp_err[2];
  logic [31:0] rsp_rdata[2];

  int wc[2] = '{1, 3};

  mips_dmem_responder_if bus0();
  mips_dmem_responder_if bus1();

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_write = req_write[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_wdata = req_wdata[0];
  assign bus0.req_be    = req_be[0];
  assign bus0.rsp_ready = rsp_ready[0];
  assign req_ready[0]   = bus0.req_ready;
  assign rsp_valid[0]   = bus0.rsp_valid;
  assign rsp_rdata[0]   = bus0.rsp_rdata;
  assign rsp_err[0]     = bus0.rsp_err;

  assign bus1.req_valid = req_valid[1];
  assign bus1.req_write = req_write[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_wdata = req_wdata[1];
  assign bus1.req_be    = req_be[1];
  assign bus1.rsp_ready = rsp_ready[1];
  assign req_ready[1]   = bus1.req_ready;
  assign rsp_valid[1]   = bus1.rsp_valid;
  assign rsp_rdata[1]   = bus1.rsp_rdata;
  assign rsp_err[1]     = bus1.rsp_err;

  mips_dmem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n[0]), .bus(bus0)
  );

  mips_dmem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n[1]), .bus(bus1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] er;
    logic        ee;
    int          bp;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic start_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[d]) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid[d] = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int d, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input string name, input int d, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] er,
                     input logic ee, input int bp);
    bit   ok;
    int   lat;
    exp_t e;
    exp_q.push_back('{rdata: er, err: ee});
    rsp_ready[d] = (bp == 0);
    start_req(d, w, a, wd, be, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      rsp_ready[d] = 1'b1;
      return;
    end
    wait_rsp(d, lat, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      rsp_ready[d] = 1'b1;
      return;
    end
    e = exp_q.pop_front();
    // lat counts falling edges; the response edge is one earlier than the sample.
    chk({name, "_latency"}, 32'(lat - 1), 32'(wc[d] + 1));
    chk({name, "_rdata"}, rsp_rdata[d], e.rdata);
    chk({name, "_err"}, {31'd0, rsp_err[d]}, {31'd0, e.err});
    for (int i = 0; i < bp; i++) begin
      chk({name, "_hold_valid"}, {31'd0, rsp_valid[d]}, 32'd1);
      chk({name, "_hold_rdata"}, rsp_rdata[d], e.rdata);
      chk({name, "_hold_req_ready"}, {31'd0, req_ready[d]}, 32'd0);
      if (i < bp - 1) @(negedge clk);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_valid_drop"}, {31'd0, rsp_valid[d]}, 32'd0);
    chk({name, "_ready_gap"}, {31'd0, req_ready[d]}, 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_ready_back"}, {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;

    for (int d = 0; d < 2; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b1;
    end

    // Reset state and release behaviour.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    chk("rel_req_ready_low", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_req_ready_high", {31'd0, req_ready[0]}, 32'd1);
    chk("rel_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);

    tbl.push_back('{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h7C, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h7D, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 0});
    tbl.push_back('{0, 1'b0, 32'h7C, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 0});
    tbl.push_back('{0, 1'b0, 32'h80, 32'h0, 4'b0000, 32'h0, 1'b1, 0});
    tbl.push_back('{0, 1'b0, 32'hFFFFFFFC, 32'h0, 4'b0000, 32'h0, 1'b1, 0});
    tbl.push_back('{0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 5});
    tbl.push_back('{0, 1'b1, 32'h14, 32'h44332211, 4'b1111, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h14, 32'hBB00CC00, 4'b1010, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b0, 32'h14, 32'h0, 4'b0000, 32'hBB33CC11, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h18, 32'h01020304, 4'b1111, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b1, 32'h18, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0});
    tbl.push_back('{0, 1'b0, 32'h18, 32'h0, 4'b0000, 32'h01020304, 1'b0, 0});
`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    tbl.push_back('{0, 1'b0, 32'h11, 32'h0, 4'b0000, 32'h0, 1'b1, 0});
`else
    tbl.push_back('{0, 1'b0, 32'h11, 32'h0, 4'b0000, 32'h11DEADBE, 1'b0, 0});
`endif
    tbl.push_back('{1, 1'b1, 32'h20, 32'h11111111, 4'b1111, 32'h0, 1'b0, 0});
    tbl.push_back('{1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11111111, 1'b0, 0});

    foreach (tbl[i]) begin
      txn($sformatf("vec%0d", i), tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be,
          tbl[i].er, tbl[i].ee, tbl[i].bp);
    end

    // Store aborted by reset while still waiting must never reach the array.
    start_req(1, 1'b1, 32'h20, 32'h12345678, 4'b1111, ok);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("wait_rst_req_ready", {31'd0, req_ready[1]}, 32'd0);
    chk("wait_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    txn("wait_rst_load", 1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11111111, 1'b0, 0);

    // Store already in RESP when reset hits stays committed.
    rsp_ready[1] = 1'b0;
    start_req(1, 1'b1, 32'h24, 32'hA5A5A5A5, 4'b1111, ok);
    wait_rsp(1, lat, ok);
    rst_n[1] = 1'b0;
    #1;
    chk("resp_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    txn("resp_rst_load", 1, 1'b0, 32'h24, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0, 0);

    // Load data register clears asynchronously on reset.
    rsp_ready[1] = 1'b0;
    start_req(1, 1'b0, 32'h24, 32'h0, 4'b0000, ok);
    wait_rsp(1, lat, ok);
    chk("async_pre_rdata", rsp_rdata[1], 32'hA5A5A5A5);
    rst_n[1] = 1'b0;
    #1;
    chk("async_rsp_rdata", rsp_rdata[1], 32'h0);
    chk("async_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
    chk("async_req_ready", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Data-memory responder for the MIPS core: the target end of the load/store interface that the core drives as initiator. Accepts one word request at a time over a valid/ready handshake, applies a programmable number of wait states, commits stores byte-lane by byte-lane into a byte-addressable little-endian array, and returns load data or an error on a separate valid/ready response channel. It replaces the core's internal `d_mem` array once the core moves to a multi-cycle/stalling memory path.

## Interface
- `DEPTH_BYTES`, 128, array size in bytes; must be a power of two and at least 4.
- `WAIT_CYCLES`, 1, wait states between request acceptance and response; legal range 0..15.
- `clk`  in  1  clock, all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address of the word.
- `req_wdata`  in  32  store data; bits 7:0 go to `addr+0`.
- `req_be`  in  4  byte enables; bit k enables `addr+k`; ignored for loads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator accepts the response.
- `rsp_rdata`  out  32  load data, little-endian; 0 for stores and errors.
- `rsp_err`  out  1  request was rejected; see Operation.

## Operation
- FSM states are IDLE, WAIT and RESP.
  - IDLE: `req_ready=1`. When `req_valid && req_ready`, capture `write/addr/wdata/be`. Go to WAIT if `WAIT_CYCLES>0`, with the counter loaded to `WAIT_CYCLES-1`. Otherwise go to RESP.
  - WAIT: `req_ready=0`. Decrement the counter each cycle; go to RESP on the cycle after the counter reads 0.
  - RESP: `rsp_valid=1`. `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`. On handshake, go to IDLE.
- On the edge entering RESP:
  - Stores: each enabled byte is written to the array.
  - Loads: the 4 bytes are sampled into the `rsp_rdata` register.
- Error: `rsp_err=1` when `req_addr > DEPTH_BYTES-4`. For an error, no array write occurs and `rsp_rdata=0`. Address upper bits beyond the array never wrap.
- A store with `req_be=0` is a legal no-op and responds with `rsp_err=0`.
- Only one transaction is outstanding at a time. A request presented outside IDLE is ignored by the responder; the initiator holds it.

## Timing
- Reset values: state IDLE, `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, counter 0.
- `req_ready` is registered. It rises on the first posedge after `rst_n` deasserts, then equals (state==IDLE).
- The array contents are not reset.
- Latency: with the request accepted at edge N, `rsp_valid` is high from edge `N+WAIT_CYCLES+1`.
- Throughput: a transaction takes at least `WAIT_CYCLES+2` cycles with `rsp_ready` tied high.
- The response handshake and IDLE re-entry happen on the same edge. `req_ready` is high the cycle after `rsp_valid` drops.
- Reset asserted mid-transaction aborts it:
  - A store still in WAIT is never committed.
  - A store already in RESP remains in the array.
  - Outputs return to reset values asynchronously.
- Back-pressure: `rsp_ready=0` holds RESP indefinitely with all outputs stable.

## Configuration
- `MIPS_DMEM_ALIGN_CHECK_EN`, when defined:
  - `req_addr[1:0]!=0` is also an error: `rsp_err=1`, no write, `rsp_rdata=0`.
- Without the macro:
  - Unaligned word accesses are legal and use bytes `addr..addr+3`, matching the core's current byte-wise access.
  - The out-of-range check still applies.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum `t_dmem_state` (IDLE, WAIT, RESP);
  - `DMEM_WORD_BYTES=4`;
  - the 4-bit wait-counter width constant.
- Sub-module `mips_dmem_bytes`:
  - holds the byte array;
  - 4-lane write port with per-lane enable;
  - 4-byte combinational read port at a base address.
- The FSM, counter, error check and response register stay in the top module.

## Test plan
- **Reset release:** reset release with `WAIT_CYCLES=1` -> `req_ready` goes 0 then 1 one edge after `rst_n` rises; `rsp_valid=0`.
- **Store then load, partial enables:**
  - Store `addr=0x10`, `wdata=0xDEADBEEF`, `be=4'b1111`.
  - Then store `addr=0x10`, `be=4'b0001`, `wdata=0x000000AA`.
  - Then load `0x10` -> `rsp_rdata=0xDEADBEAA`, `rsp_err=0`, response 2 cycles after acceptance.
- **Out-of-range store:** store `addr=0x7D` (`DEPTH_BYTES=128`) -> `rsp_err=1`; a following load of `0x7C` returns the old contents unchanged.
- **Response back-pressure:** `rsp_ready` low for 5 cycles after a load of `0x10` -> `rsp_valid` and `rsp_rdata=0xDEADBEAA` stable all 5 cycles; `req_ready=0` throughout.
- **Reset during WAIT:**
  - Set `WAIT_CYCLES=3`; store `0x20`, `wdata=0x12345678`.
  - Assert `rst_n=0` during WAIT, release, then load `0x20` -> the store was not written.
  - Compare against a prior known value of `0x11111111` written before the store.
- **Alignment check:** with `MIPS_DMEM_ALIGN_CHECK_EN`, load `0x11` -> `rsp_err=1`, `rsp_rdata=0`. Without the macro, the same load returns bytes `0x11..0x14`.
